// File: rtl/sha256_id_buffer.sv
// First-word-fall-through FIFO of {last, id} entries feeding sha256_id_validator.
// Entries leave in arrival order; occupancy is tracked by a registered counter.
module sha256_id_buffer #(
  parameter int ID_W = 6,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              sync_rst,
  input  logic [ID_W-1:0]   id_in,
  input  logic              id_in_last,
  input  logic              id_in_valid,
  output logic              id_in_ready,
  output logic [ID_W-1:0]   id_out,
  output logic              id_out_last,
  output logic              id_out_valid,
  input  logic              id_out_ready,
  output logic [ADDR_W:0]   status_count,
  output logic              status_full,
  output logic              status_empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

  logic [ID_W:0]   mem_r [DEPTH];
  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic [ADDR_W:0] count_r;
  logic            full_s;
  logic            empty_s;
  logic            active_s;
  logic            push_s;
  logic            pop_s;
  logic [ID_W:0]   head_s;

  // Wrap bit distinguishes full from empty when the addresses coincide.
  assign full_s   = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                    (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign active_s = nrst && en && !sync_rst;

  assign id_in_ready  = active_s && !full_s;
  assign id_out_valid = active_s && !empty_s;
  assign push_s       = id_in_valid && id_in_ready;
  assign pop_s        = id_out_valid && id_out_ready;

  // Storage array; contents survive flushes and are masked at the output when empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= {id_in_last, id_in};
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= {(ADDR_W + 1){1'b0}};
      rd_ptr_r <= {(ADDR_W + 1){1'b0}};
    end else if (sync_rst) begin
      wr_ptr_r <= {(ADDR_W + 1){1'b0}};
      rd_ptr_r <= {(ADDR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_r <= {(ADDR_W + 1){1'b0}};
    end else if (sync_rst) begin
      count_r <= {(ADDR_W + 1){1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + PTR_ONE;
        2'b01:   count_r <= count_r - PTR_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head-of-queue mux, forced to zero while empty so reset state reads as 0.
  always_comb begin
    head_s = {(ID_W + 1){1'b0}};
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r[ADDR_W-1:0]];
    end else begin
      head_s = {(ID_W + 1){1'b0}};
    end
  end

  assign id_out       = head_s[ID_W-1:0];
  assign id_out_last  = head_s[ID_W];
  assign status_count = count_r;
  assign status_full  = (count_r == FULL_CNT);
  assign status_empty = (count_r == {(ADDR_W + 1){1'b0}});

endmodule

// File: tb/tb_sha256_id_buffer.sv
// Randomised bench for sha256_id_buffer against a queue-based reference model.
module tb_sha256_id_buffer;

  localparam int ID_W = 6;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            en = 1'b1;
  logic            sync_rst = 1'b0;
  logic [ID_W-1:0] id_in = '0;
  logic            id_in_last = 1'b0;
  logic            id_in_valid = 1'b0;
  logic            id_in_ready;
  logic [ID_W-1:0] id_out;
  logic            id_out_last;
  logic            id_out_valid;
  logic            id_out_ready = 1'b0;
  logic [3:0]      status_count;
  logic            status_full;
  logic            status_empty;

  int checks = 0;
  int errors = 0;
  logic [ID_W:0] model_q[$];
  logic [ID_W:0] out_log[$];

  sha256_id_buffer #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
    .id_in(id_in), .id_in_last(id_in_last), .id_in_valid(id_in_valid),
    .id_in_ready(id_in_ready), .id_out(id_out), .id_out_last(id_out_last),
    .id_out_valid(id_out_valid), .id_out_ready(id_out_ready),
    .status_count(status_count), .status_full(status_full),
    .status_empty(status_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue with a capacity of DEPTH.
  initial begin
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        model_q.delete();
      end else if (sync_rst) begin
        model_q.delete();
      end else begin
        bit can_push, can_pop;
        can_push = en && id_in_valid && (model_q.size() < DEPTH);
        can_pop  = en && id_out_ready && (model_q.size() != 0);
        if (can_pop) void'(model_q.pop_front());
        if (can_push) model_q.push_back({id_in_last, id_in});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic act_ok;
        logic [ID_W:0] head;
        int n;
        n = model_q.size();
        act_ok = nrst && en && !sync_rst;
        head = (n != 0) ? model_q[0] : '0;
        chk("in_ready", id_in_ready, act_ok && (n < DEPTH));
        chk("out_valid", id_out_valid, act_ok && (n != 0));
        chk("count", status_count, n);
        chk("full", status_full, n == DEPTH);
        chk("empty", status_empty, n == 0);
        chk("head", {id_out_last, id_out}, head);
        if (id_out_valid && id_out_ready) out_log.push_back({id_out_last, id_out});
      end
    end
  end

  task automatic push(input logic [ID_W-1:0] id, input logic last);
    logic acc;
    int t;
    id_in = id;
    id_in_last = last;
    id_in_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = id_in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    id_in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    id_out_ready = 1'b1;
    t = 0;
    while (model_q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) chk("drain_timeout", 32'd0, 32'd1);
    id_out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", status_empty, 1'b1);
    chk("rst_ready", id_in_ready, 1'b0);
    chk("rst_id_out", id_out, 6'h00);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // 1: three IDs straight through
    id_out_ready = 1'b1;
    out_log.delete();
    push(6'h01, 1'b0);
    chk("t1_latency_valid", id_out_valid, 1'b1);
    chk("t1_latency_id", id_out, 6'h01);
    push(6'h02, 1'b0);
    push(6'h03, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_log_n", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("t1_o0", out_log[0], 7'h01);
      chk("t1_o1", out_log[1], 7'h02);
      chk("t1_o2", out_log[2], 7'h43);
    end
    chk("t1_count", status_count, 4'd0);

    // 2: fill, hold off the 9th, one pop admits it
    id_out_ready = 1'b0;
    out_log.delete();
    for (int i = 0; i < 8; i++) push(6'h10 + 6'(i), 1'b0);
    chk("t2_full", status_full, 1'b1);
    chk("t2_ready", id_in_ready, 1'b0);
    id_in = 6'h18;
    id_in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t2_held_count", status_count, 4'd8);
    id_out_ready = 1'b1;
    @(negedge clk);
    chk("t2_pop_head", id_out, 6'h10);
    @(posedge clk);
    #1;
    id_out_ready = 1'b0;
    chk("t2_after_pop", status_count, 4'd7);
    @(posedge clk);
    #1;
    id_in_valid = 1'b0;
    chk("t2_accept", status_count, 4'd8);
    drain();
    chk("t2_log_n", out_log.size(), 9);
    for (int i = 0; i < 9 && i < out_log.size(); i++) chk("t2_log", out_log[i], 7'h10 + 7'(i));

    // 3: wrap with random gaps and stalls
    out_log.delete();
    begin
      int sent, cyc;
      logic acc;
      sent = 0;
      cyc = 0;
      while ((sent < 20 || out_log.size() < 20) && cyc < 2000) begin
        id_in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
        id_in = 6'(sent);
        id_in_last = (sent % 5 == 4);
        id_out_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        acc = id_in_valid && id_in_ready;
        @(posedge clk);
        #1;
        if (acc) sent++;
        cyc++;
      end
      if (cyc >= 2000) chk("t3_timeout", 32'd0, 32'd1);
    end
    id_in_valid = 1'b0;
    id_out_ready = 1'b0;
    chk("t3_log_n", out_log.size(), 20);
    for (int i = 0; i < 20 && i < out_log.size(); i++)
      chk("t3_log", out_log[i], {(i % 5 == 4), 6'(i)});

    // 4: count 4, simultaneous push and pop
    for (int i = 0; i < 4; i++) push(6'h20 + 6'(i), 1'b0);
    chk("t4_count", status_count, 4'd4);
    id_in = 6'h24;
    id_in_valid = 1'b1;
    id_out_ready = 1'b1;
    @(posedge clk);
    #1;
    id_in_valid = 1'b0;
    id_out_ready = 1'b0;
    chk("t4_count_same", status_count, 4'd4);
    chk("t4_head", id_out, 6'h21);

    // 5: count 5, en low for 10 cycles with both sides requesting
    push(6'h25, 1'b1);
    en = 1'b0;
    id_in_valid = 1'b1;
    id_out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t5_ready", id_in_ready, 1'b0);
      chk("t5_valid", id_out_valid, 1'b0);
      chk("t5_count", status_count, 4'd5);
    end
    @(posedge clk);
    #1;
    id_in_valid = 1'b0;
    id_out_ready = 1'b0;
    en = 1'b1;
    #1;
    chk("t5_resume_valid", id_out_valid, 1'b1);
    chk("t5_resume_head", id_out, 6'h21);

    // 6: count 6, sync flush then async reset mid-burst
    push(6'h26, 1'b0);
    chk("t6_count", status_count, 4'd6);
    sync_rst = 1'b1;
    id_in_valid = 1'b1;
    @(posedge clk);
    #1;
    sync_rst = 1'b0;
    id_in_valid = 1'b0;
    chk("t6_flush_count", status_count, 4'd0);
    chk("t6_flush_empty", status_empty, 1'b1);
    chk("t6_flush_valid", id_out_valid, 1'b0);
    push(6'h30, 1'b0);
    push(6'h31, 1'b0);
    push(6'h32, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_rst_count", status_count, 4'd0);
    chk("t6_rst_empty", status_empty, 1'b1);
    chk("t6_rst_full", status_full, 1'b0);
    chk("t6_rst_valid", id_out_valid, 1'b0);
    chk("t6_rst_ready", id_in_ready, 1'b0);
    chk("t6_rst_id", {id_out_last, id_out}, 7'h00);
    repeat (2) @(negedge clk);
    #2;
    nrst = 1'b1;
    push(6'h3f, 1'b1);
    chk("t6_recover_head", {id_out_last, id_out}, 7'h7f);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
